// File: rtl/ps2_scancode_rx_pkg.sv
// ps2_scancode_rx_pkg
//   Shared definitions for the PS/2 scancode receiver: deframer state
//   encoding and the default build-time constants.
//   Build option: PS2_PARITY_CHECK_EN (see ps2_scancode_rx.sv).
package ps2_scancode_rx_pkg;

  localparam int DEF_FIFO_DEPTH     = 8;      // scancode buffer entries
  localparam int DEF_FILTER_LEN     = 8;      // equal samples to accept a ps2clk change
  localparam int DEF_TIMEOUT_CYCLES = 14000;  // 2 ms at 7 MHz

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

endpackage

// File: rtl/ps2_scancode_rx_fifo.sv
// scancode_fifo
//   Circular scancode buffer between the PS/2 deframer and the CPU read path.
//   Ports:
//     clk, rst      - clock, asynchronous active-high reset
//     push          - write push_data this cycle (dropped when full unless popping)
//     push_data     - byte to store
//     pop           - remove head entry (ignored when empty)
//     dout          - head entry, all zeros when empty
//     empty, count  - occupancy
//     overflow      - sticky, set when a push was dropped, cleared by an accepted pop
//   Handshake: push and pop are single-cycle strobes; there is no ready
//   signal, acceptance is decided purely by occupancy in the same cycle.
module scancode_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             do_pop, do_push, full;

  always_comb begin
    full    = (count_q == FULL_CNT);
    do_pop  = pop && (count_q != '0);
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    do_push = push && (!full || do_pop);

    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    // Pointers are AW bits wide, so the increment wraps modulo DEPTH.
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;

    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;

    if (do_pop)                overflow_d = 1'b0;
    else if (push && !do_push) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset: dout is masked to zero whenever count is zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign dout     = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx
//   Deframes PS/2 device-to-host traffic (start, 8 data LSB first, parity,
//   stop) and buffers accepted scancodes for the CPU register read path.
//   Ports:
//     clk, rst         - 7 MHz system clock, asynchronous active-high reset
//     ps2clk, ps2data  - raw asynchronous PS/2 lines
//     rd_strobe        - one-cycle pop per CPU read, ignored when empty
//     dout             - head scancode (8'h00 when empty)
//     empty, count     - buffer occupancy
//     overflow         - sticky: a byte was dropped because the buffer was full
//     frame_err        - one-cycle pulse on a rejected or timed-out frame
//     state_dbg        - current deframer state (rx_state_t encoding)
//   Build option: define PS2_PARITY_CHECK_EN to reject frames whose 9-bit
//   data+parity is not odd; otherwise the parity bit is consumed and ignored.
module ps2_scancode_rx
  import ps2_scancode_rx_pkg::*;
#(
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int FILTER_LEN     = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2clk,
  input  logic                          ps2data,
  input  logic                          rd_strobe,
  output logic [7:0]                    dout,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          frame_err,
  output logic [1:0]                    state_dbg
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT_CYCLES - 1);

  // Synchronizers reset high: an idle PS/2 bus has both lines released.
  logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2data;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Glitch filter: count consecutive samples that differ from the accepted
  // level; the level flips on the FILTER_LEN-th one.
  logic           filt_q, filt_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
  logic           fall;

  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FILT_LAST) filt_d = clk_s2_q;
      else                         filt_cnt_d = filt_cnt_q + 1'b1;
    end
    fall = filt_q && !filt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // Deframer
  rx_state_t      state_q, state_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic           push_q, push_d;
  logic [7:0]     push_data_q, push_data_d;
  logic           err_q, err_d;
  logic           frame_ok;
`ifdef PS2_PARITY_CHECK_EN
  logic           parity_q, parity_d;
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tmo_d       = '0;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    err_d       = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    parity_d    = parity_q;
    frame_ok    = dat_s2_q && (^{parity_q, shift_q});
`else
    frame_ok    = dat_s2_q;
`endif

    if (fall) begin
      case (state_q)
        ST_IDLE: begin
          // A high sample here is line noise, not a start bit.
          if (!dat_s2_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        ST_DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
        ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          parity_d = dat_s2_q;
`endif
          state_d  = ST_STOP;
        end
        default: begin  // ST_STOP
          if (frame_ok) begin
            push_d      = 1'b1;
            push_data_d = shift_q;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tmo_q == TMO_LAST) begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tmo_q       <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      err_q       <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tmo_q       <= tmo_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      err_q       <= err_d;
`ifdef PS2_PARITY_CHECK_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign frame_err = err_q;
  assign state_dbg = state_q;

  scancode_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (push_data_q),
    .pop       (rd_strobe),
    .dout      (dout),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_ps2_scancode_rx.sv
module tb_ps2_scancode_rx;
  import ps2_scancode_rx_pkg::*;

  localparam int DEPTH = 8;
  localparam int TMO   = 14000;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // Clock / reset
  logic       clk = 1'b0;
  logic       rst;
  logic       ps2clk, ps2data, rd_strobe;
  logic [7:0] dout;
  logic       empty, overflow, frame_err;
  logic [3:0] count;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  ps2_scancode_rx #(
    .FIFO_DEPTH     (DEPTH),
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2clk    (ps2clk),
    .ps2data   (ps2data),
    .rd_strobe (rd_strobe),
    .dout      (dout),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .frame_err (frame_err),
    .state_dbg (state_dbg)
  );

  // Scoreboard / reference model
  int         checks   = 0;
  int         failures = 0;
  int         err_seen = 0;
  int         exp_err  = 0;
  logic [7:0] exp_q[$];
  bit         exp_ovf  = 1'b0;

  // Every high cycle of frame_err is counted, so a stretched pulse shows up.
  always @(negedge clk) begin
    if (frame_err === 1'b1) err_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [7:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
    check({tag, ":count"},    {28'd0, count},        32'(exp_q.size()));
    check({tag, ":empty"},    {31'd0, empty},        32'(exp_q.size() == 0));
    check({tag, ":dout"},     {24'd0, dout},         {24'd0, head});
    check({tag, ":overflow"}, {31'd0, overflow},     {31'd0, exp_ovf});
    check({tag, ":frame_err"}, 32'(err_seen),        32'(exp_err));
    check({tag, ":state"},    {30'd0, state_dbg},    32'(ST_IDLE));
  endtask

  // Driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives the first nbits of a frame. With pop_at_stop, rd_strobe is pulsed
  // in the cycle the stop-bit byte reaches the buffer: 2 sync stages plus
  // 8 filter samples after the raw falling edge, then one more cycle.
  task automatic send_bits(input logic [7:0] b, input bit par_good, input bit stop,
                           input int nbits, input bit pop_at_stop);
    logic [10:0] fr;
    logic        par;
    par = par_good ? ~^b : ^b;
    fr  = {stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2data = fr[i];
      wait_cyc(9);
      ps2clk = 1'b0;
      if (pop_at_stop && i == 10) begin
        wait_cyc(10);
        rd_strobe = 1'b1;
        wait_cyc(1);
        rd_strobe = 1'b0;
        wait_cyc(9);
      end else begin
        wait_cyc(20);
      end
      ps2clk = 1'b1;
      wait_cyc(10);
    end
    ps2data = 1'b1;
  endtask

  task automatic do_frame(input logic [7:0] b, input bit par_good, input bit stop,
                          input bit pop_at_stop);
    bit valid;
    send_bits(b, par_good, stop, 11, pop_at_stop);
    if (pop_at_stop && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      exp_ovf = 1'b0;
    end
    valid = stop && (par_good || !PAR_EN);
    if (valid) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else                      exp_ovf = 1'b1;
    end else begin
      exp_err++;
    end
    wait_cyc(5);
  endtask

  task automatic do_read();
    @(negedge clk);
    rd_strobe = 1'b1;
    @(negedge clk);
    rd_strobe = 1'b0;
    if (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      exp_ovf = 1'b0;
    end
    wait_cyc(1);
  endtask

  initial begin
    rst       = 1'b1;
    ps2clk    = 1'b1;
    ps2data   = 1'b1;
    rd_strobe = 1'b0;
    wait_cyc(3);
    check_state("reset");
    rst = 1'b0;
    wait_cyc(5);

    // Short low glitch on ps2clk while idle
    ps2clk = 1'b0;
    wait_cyc(3);
    ps2clk = 1'b1;
    wait_cyc(20);
    check_state("glitch");

    // Valid 0x1C frame, then read it back
    do_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    check_state("f1c");
    do_read();
    check_state("f1c_read");

    // 0x1C with wrong parity: rejected only when parity checking is built in
    do_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check_state("f1c_badpar");
    if (exp_q.size() > 0) do_read();
    check_state("f1c_badpar_drain");

    // Bad stop bit always rejected
    do_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    check_state("bad_stop");

    // Nine frames without reads: last one dropped, overflow set
    for (int i = 1; i <= 9; i++) do_frame(8'(i), 1'b1, 1'b1, 1'b0);
    check_state("ovf9");
    do_read();
    check_state("ovf_read");

    // Refill to full, then push and pop in the same cycle
    do_frame(8'h0A, 1'b1, 1'b1, 1'b0);
    check_state("refull");
    do_frame(8'h0B, 1'b1, 1'b1, 1'b1);
    check_state("full_pushpop");
    while (exp_q.size() > 0) do_read();
    check_state("drained");
    do_read();
    check_state("read_empty");

    // Push and pop together while empty: pop ignored
    do_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    check_state("empty_pushpop");

    // Reset in the middle of a frame: no frame_err, buffer lost
    do_frame(8'h11, 1'b1, 1'b1, 1'b0);
    send_bits(8'h77, 1'b1, 1'b1, 4, 1'b0);
    rst = 1'b1;
    wait_cyc(2);
    exp_q.delete();
    exp_ovf = 1'b0;
    check_state("midframe_rst");
    rst = 1'b0;
    wait_cyc(5);

    // Start + 5 data bits then silence: timeout aborts the frame
    send_bits(8'h5A, 1'b1, 1'b1, 6, 1'b0);
    wait_cyc(100);
    check("tmo_pending:frame_err", 32'(err_seen), 32'(exp_err));
    check("tmo_pending:state", {30'd0, state_dbg}, 32'(ST_DATA));
    wait_cyc(15000);
    exp_err++;
    check_state("timeout");
    do_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    check_state("after_timeout");
    do_read();

    // Randomized frames and reads against the model
    for (int n = 0; n < 30; n++) begin
      logic [7:0] b;
      bit         pg, sb;
      b  = 8'($urandom_range(0, 255));
      pg = ($urandom_range(0, 3) != 0);
      sb = ($urandom_range(0, 5) != 0);
      do_frame(b, pg, sb, 1'b0);
      check_state("rand_frame");
      if ($urandom_range(0, 2) == 0) begin
        do_read();
        check_state("rand_read");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
